mult_arbiter: RTL and testbench
===============================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the operand width in bits; results SHALL be 2W bits.
REQ-002 The block SHALL have one clock; reset is synchronous and active-low.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 req0_valid / req1_valid  in  1  requester n has an operand pair pending.
REQ-006 req0_a, req0_b / req1_a, req1_b  in  W  operands for requester n.
REQ-007 req0_ready / req1_ready  out  1  one-cycle pulse: requester n's operands accepted this cycle.
REQ-008 rsp0_valid / rsp1_valid  out  1  result held for requester n.
REQ-009 rsp0_data / rsp1_data  out  2W  product for requester n.
REQ-010 rsp0_taken / rsp1_taken  in  1  requester n consumes its result.
REQ-011 m_input_available  out  1  start strobe to the shared multiplier.
REQ-012 m_a, m_b  out  W  operands to the multiplier.
REQ-013 m_result_rdy  in  1  multiplier result valid.
REQ-014 m_result  in  2W  multiplier product.
REQ-015 m_result_taken  out  1  releases the multiplier back to its wait state.
REQ-016 grant_id  out  1  owner of the current transaction; busy  out  1  high in any state except IDLE.

Function
REQ-017 The FSM SHALL have four states: IDLE, ISSUE, WAIT_RES, DELIVER.
REQ-018 IDLE: if any req valid, pick the winner, pulse its ready, latch a/b into op regs, set owner, go to ISSUE; otherwise stay.
REQ-019 Arbitration SHALL be round-robin: pointer rr names the favoured requester; a lone valid requester wins regardless of rr.
REQ-020 ISSUE: m_input_available=1 for exactly one cycle with m_a/m_b equal to the latched ops; next state is WAIT_RES.
REQ-021 m_a/m_b SHALL equal the latched ops in all states (stable through the calculation); they SHALL be 0 after reset.
REQ-022 WAIT_RES: on m_result_rdy=1, capture m_result into the owner's rsp register, assert m_result_taken in that same cycle (combinational), go to DELIVER.
REQ-023 m_result_taken SHALL be 0 in every other cycle.
REQ-024 DELIVER: rsp<owner>_valid=1 with stable data until rsp<owner>_taken=1, then rr<=~owner and go to IDLE.
REQ-025 A taken on the non-owner, or a taken while valid=0, SHALL be ignored.
REQ-026 req_valid is sampled only in IDLE; a requester drops valid before ready at no cost, and no request is queued.
REQ-027 Latency: ready pulse at cycle t; rsp_valid at t + 2 + (multiplier cycles to m_result_rdy); no back-to-back issue, so the next ready is no earlier than 1 cycle after taken.
REQ-028 The other requester's rsp_valid SHALL remain 0 throughout a transaction.

Reset
REQ-029 When reset=0 at a clock edge: state=IDLE, rr=0 (requester 0 favoured), owner=0, ops=0, rsp data=0.
REQ-030 All outputs SHALL be 0 during and after reset, including mid-operation; any in-flight transaction is discarded.

Structure
REQ-031 Package mult_arb_pkg SHALL hold the state encoding (IDLE=0, ISSUE=1, WAIT_RES=2, DELIVER=3, 2 bits) and the default W.
REQ-032 Winner selection SHALL be a combinational sub-module mult_rr_pick with inputs (valid[1:0], rr) and outputs (any, winner).
REQ-033 The state register SHALL be a separate clocked process; next-state and output logic SHALL be combinational with defaults.

Verification
REQ-034 Single request: req0 a=6, b=7 -> one ready0 pulse, one m_input_available pulse, rsp0_data=42 held until taken; rsp1_valid stays 0.
REQ-035 Simultaneous: both valid after reset, req0 3x4, req1 5x5 -> req0 served first (12), then req1 (25); a second simultaneous round after that serves req1 first.
REQ-036 Zero/max: 0x9 -> 0; 255x255 (W=8) -> 65025.
REQ-037 Slow consumer: hold rsp1_taken=0 for 20 cycles -> rsp1_valid and data stable, no new ready pulses, m_result_taken pulsed once only.
REQ-038 Reset mid-WAIT_RES -> next cycle all outputs 0, state IDLE, rr=0; a fresh req1 completes correctly.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// -----------------------------------------------------------------------------
// mult_arb_pkg
// Shared definitions for the two-requester multiplier arbiter: the default
// operand width and the arbiter FSM state encoding.
// -----------------------------------------------------------------------------
package mult_arb_pkg;

    // Default operand width; products are twice this wide.
    localparam int DEFAULT_W = 8;

    // Arbiter FSM states, fixed 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RES = 2'd2,
        DELIVER  = 2'd3
    } state_e;

endpackage : mult_arb_pkg

// File: rtl/mult_rr_pick.sv
// -----------------------------------------------------------------------------
// mult_rr_pick
// Combinational round-robin winner selection between two requesters.
//
// Ports:
//   valid  [1:0] in   request pending per requester
//   rr           in   favoured requester when both are valid
//   any          out  at least one requester is valid
//   winner       out  index of the selected requester (meaningful when any=1)
// -----------------------------------------------------------------------------
module mult_rr_pick (
    input  logic [1:0] valid,
    input  logic       rr,
    output logic       any,
    output logic       winner
);

    always_comb begin
        any = |valid;
        // Contention goes to the favoured side; a lone requester wins outright.
        if (&valid) begin
            winner = rr;
        end else begin
            winner = valid[1];
        end
    end

endmodule : mult_rr_pick

// File: rtl/mult_arbiter.sv
// -----------------------------------------------------------------------------
// mult_arbiter
// Shares one external multiplier between two requesters. One transaction is in
// flight at a time: grant and latch operands (IDLE), strobe the multiplier
// (ISSUE), wait for and capture its product (WAIT_RES), then hold the result
// for the owner until it is taken (DELIVER). Contention is resolved round-robin.
//
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   req<n>_valid/_a/_b         requester n operand pair and its valid
//   req<n>_ready               one-cycle accept pulse for requester n
//   rsp<n>_valid/_data         result held for requester n
//   rsp<n>_taken               requester n consumes its result
//   m_input_available          start strobe to the multiplier
//   m_a, m_b                   operands to the multiplier (latched values)
//   m_result_rdy, m_result     multiplier product and its valid
//   m_result_taken             releases the multiplier
//   grant_id                   owner of the current transaction
//   busy                       FSM is not in IDLE
// -----------------------------------------------------------------------------
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req0_valid,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    input  logic           req1_valid,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    output logic           req0_ready,
    output logic           req1_ready,
    output logic           rsp0_valid,
    output logic [2*W-1:0] rsp0_data,
    output logic           rsp1_valid,
    output logic [2*W-1:0] rsp1_data,
    input  logic           rsp0_taken,
    input  logic           rsp1_taken,
    output logic           m_input_available,
    output logic [W-1:0]   m_a,
    output logic [W-1:0]   m_b,
    input  logic           m_result_rdy,
    input  logic [2*W-1:0] m_result,
    output logic           m_result_taken,
    output logic           grant_id,
    output logic           busy
);

    state_e         state_q, state_d;
    logic           rr_q, rr_d;
    logic           owner_q, owner_d;
    logic [W-1:0]   op_a_q, op_a_d;
    logic [W-1:0]   op_b_q, op_b_d;
    logic [2*W-1:0] rsp0_q, rsp0_d;
    logic [2*W-1:0] rsp1_q, rsp1_d;

    logic           pick_any;
    logic           pick_winner;

    // Raw (ungated) strobes produced by the FSM decode.
    logic           ready0_c, ready1_c;
    logic           start_c, mtaken_c;
    logic           deliver0_c, deliver1_c;

    mult_rr_pick u_pick (
        .valid  ({req1_valid, req0_valid}),
        .rr     (rr_q),
        .any    (pick_any),
        .winner (pick_winner)
    );

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples the values of the previous cycle, race-free.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_q    <= 1'b0;
            owner_q <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            rsp0_q  <= '0;
            rsp1_q  <= '0;
        end else begin
            rr_q    <= rr_d;
            owner_q <= owner_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            rsp0_q  <= rsp0_d;
            rsp1_q  <= rsp1_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        owner_d    = owner_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        rsp0_d     = rsp0_q;
        rsp1_d     = rsp1_q;
        ready0_c   = 1'b0;
        ready1_c   = 1'b0;
        start_c    = 1'b0;
        mtaken_c   = 1'b0;
        deliver0_c = 1'b0;
        deliver1_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    owner_d  = pick_winner;
                    op_a_d   = pick_winner ? req1_a : req0_a;
                    op_b_d   = pick_winner ? req1_b : req0_b;
                    ready0_c = ~pick_winner;
                    ready1_c = pick_winner;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                start_c = 1'b1;
                state_d = WAIT_RES;
            end
            WAIT_RES: begin
                if (m_result_rdy) begin
                    // Release the multiplier in the same cycle the product is captured.
                    mtaken_c = 1'b1;
                    if (owner_q) begin
                        rsp1_d = m_result;
                    end else begin
                        rsp0_d = m_result;
                    end
                    state_d = DELIVER;
                end
            end
            DELIVER: begin
                deliver0_c = ~owner_q;
                deliver1_c = owner_q;
                // Only the owner's taken ends the transaction; the other is ignored.
                if (owner_q ? rsp1_taken : rsp0_taken) begin
                    rr_d    = ~owner_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: reset is synchronous, so the registers still hold stale values in
    // the cycle reset is first seen; gating every output with reset keeps the
    // interface quiet from that very cycle, even mid-transaction.
    assign req0_ready        = reset & ready0_c;
    assign req1_ready        = reset & ready1_c;
    assign rsp0_valid        = reset & deliver0_c;
    assign rsp1_valid        = reset & deliver1_c;
    assign rsp0_data         = reset ? rsp0_q : '0;
    assign rsp1_data         = reset ? rsp1_q : '0;
    assign m_input_available = reset & start_c;
    assign m_a               = reset ? op_a_q : '0;
    assign m_b               = reset ? op_b_q : '0;
    assign m_result_taken    = reset & mtaken_c;
    assign grant_id          = reset & owner_q;
    assign busy              = reset & (state_q != IDLE);

endmodule : mult_arbiter

// File: tb/tb_mult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mult_arbiter
// Directed self-checking bench for mult_arbiter (W=8) with a behavioural
// multiplier whose latency is set per scenario.
// Inputs change 2 time units after the falling edge; outputs are read shortly
// after that, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_mult_arbiter;

    localparam int W        = 8;
    localparam int MAX_WAIT = 60;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           req0_valid = 1'b0;
    logic [W-1:0]   req0_a = '0;
    logic [W-1:0]   req0_b = '0;
    logic           req1_valid = 1'b0;
    logic [W-1:0]   req1_a = '0;
    logic [W-1:0]   req1_b = '0;
    logic           req0_ready, req1_ready;
    logic           rsp0_valid, rsp1_valid;
    logic [2*W-1:0] rsp0_data, rsp1_data;
    logic           rsp0_taken = 1'b0;
    logic           rsp1_taken = 1'b0;
    logic           m_input_available;
    logic [W-1:0]   m_a, m_b;
    logic           m_result_rdy;
    logic [2*W-1:0] m_result;
    logic           m_result_taken;
    logic           grant_id;
    logic           busy;

    int checks   = 0;
    int failures = 0;
    int mult_lat = 2;

    int cnt_ready0 = 0;
    int cnt_ready1 = 0;
    int cnt_mia    = 0;
    int cnt_mrt    = 0;
    int cnt_rspv0  = 0;
    int cnt_rspv1  = 0;

    mult_arbiter #(.W(W)) dut (
        .clk               (clk),
        .reset             (reset),
        .req0_valid        (req0_valid),
        .req0_a            (req0_a),
        .req0_b            (req0_b),
        .req1_valid        (req1_valid),
        .req1_a            (req1_a),
        .req1_b            (req1_b),
        .req0_ready        (req0_ready),
        .req1_ready        (req1_ready),
        .rsp0_valid        (rsp0_valid),
        .rsp0_data         (rsp0_data),
        .rsp1_valid        (rsp1_valid),
        .rsp1_data         (rsp1_data),
        .rsp0_taken        (rsp0_taken),
        .rsp1_taken        (rsp1_taken),
        .m_input_available (m_input_available),
        .m_a               (m_a),
        .m_b               (m_b),
        .m_result_rdy      (m_result_rdy),
        .m_result          (m_result),
        .m_result_taken    (m_result_taken),
        .grant_id          (grant_id),
        .busy              (busy)
    );

    always #10 clk = ~clk;

    // Behavioural multiplier: product appears mult_lat+1 cycles after the
    // start strobe and is held until the arbiter takes it.
    logic       pend_start = 1'b0;
    logic       pend_taken = 1'b0;
    logic       mul_busy   = 1'b0;
    int         mul_cnt    = 0;
    logic [7:0] mul_a      = '0;
    logic [7:0] mul_b      = '0;

    initial begin
        m_result_rdy = 1'b0;
        m_result     = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                m_result_rdy = 1'b0;
                m_result     = '0;
                mul_busy     = 1'b0;
            end else begin
                if (pend_taken) begin
                    m_result_rdy = 1'b0;
                    m_result     = '0;
                end
                if (pend_start) begin
                    mul_busy = 1'b1;
                    mul_cnt  = mult_lat;
                end
                if (mul_busy) begin
                    if (mul_cnt == 0) begin
                        m_result_rdy = 1'b1;
                        m_result     = {8'd0, mul_a} * {8'd0, mul_b};
                        mul_busy     = 1'b0;
                    end else begin
                        mul_cnt--;
                    end
                end
            end
            #1;
            if (reset) begin
                pend_start = m_input_available;
                pend_taken = m_result_rdy & m_result_taken;
                if (m_input_available) begin
                    mul_a = m_a;
                    mul_b = m_b;
                end
            end else begin
                pend_start = 1'b0;
                pend_taken = 1'b0;
            end
        end
    end

    // Pulse/occupancy monitor, sampled late in the low phase.
    initial begin
        forever begin
            @(negedge clk);
            #8;
            if (req0_ready === 1'b1)        cnt_ready0++;
            if (req1_ready === 1'b1)        cnt_ready1++;
            if (m_input_available === 1'b1) cnt_mia++;
            if (m_result_taken === 1'b1)    cnt_mrt++;
            if (rsp0_valid === 1'b1)        cnt_rspv0++;
            if (rsp1_valid === 1'b1)        cnt_rspv1++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic clear_counts();
        cnt_ready0 = 0;
        cnt_ready1 = 0;
        cnt_mia    = 0;
        cnt_mrt    = 0;
        cnt_rspv0  = 0;
        cnt_rspv1  = 0;
    endtask

    task automatic set_req(input int n, input logic v, input logic [7:0] a, input logic [7:0] b);
        if (n == 0) begin
            req0_valid = v; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b;
        end
    endtask

    task automatic set_valid(input int n, input logic v);
        if (n == 0) req0_valid = v;
        else        req1_valid = v;
    endtask

    task automatic set_taken(input int n, input logic v);
        if (n == 0) rsp0_taken = v;
        else        rsp1_taken = v;
    endtask

    function automatic logic rdy_of(input int n);
        return (n == 0) ? req0_ready : req1_ready;
    endfunction

    function automatic logic rspv_of(input int n);
        return (n == 0) ? rsp0_valid : rsp1_valid;
    endfunction

    function automatic logic [15:0] rspd_of(input int n);
        return (n == 0) ? rsp0_data : rsp1_data;
    endfunction

    function automatic int rspcnt_of(input int n);
        return (n == 0) ? cnt_rspv0 : cnt_rspv1;
    endfunction

    // One complete transaction for requester 'owner', entered in IDLE. The
    // other requester's valid/operands are left as the caller set them; with
    // 'pressure' the other requester raises valid while the result is held.
    task automatic do_txn(input int owner, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp, input int hold, input bit pressure);
        int   other;
        int   waited;
        int   unstable;
        logic own_bit;
        other   = 1 - owner;
        own_bit = owner[0];
        clear_counts();
        set_req(owner, 1'b1, a, b);
        #1;
        checks++;
        if (rdy_of(owner) !== 1'b1 || rdy_of(other) !== 1'b0) begin
            failures++;
            $display("FAIL grant_req%0d: ready%0d=%b ready%0d=%b, required 1 and 0",
                     owner, owner, rdy_of(owner), other, rdy_of(other));
        end
        tick();
        set_valid(owner, 1'b0);
        #1;
        checks++;
        if (m_input_available !== 1'b1 || m_a !== a || m_b !== b || busy !== 1'b1 || grant_id !== own_bit) begin
            failures++;
            $display("FAIL issue_req%0d: start=%b m_a=%0d m_b=%0d busy=%b grant=%b, required 1 %0d %0d 1 %b",
                     owner, m_input_available, m_a, m_b, busy, grant_id, a, b, own_bit);
        end
        waited = 0;
        while (rspv_of(owner) !== 1'b1 && waited < MAX_WAIT) begin
            tick();
            #1;
            waited++;
        end
        checks++;
        if (waited != mult_lat + 2) begin
            failures++;
            $display("FAIL latency_req%0d: rsp_valid after %0d cycles from issue, required %0d",
                     owner, waited, mult_lat + 2);
        end
        checks++;
        if (rspd_of(owner) !== exp || grant_id !== own_bit || rspcnt_of(other) != 0) begin
            failures++;
            $display("FAIL data_req%0d: data=%0d grant=%b other_valid_cycles=%0d, required %0d %b 0",
                     owner, rspd_of(owner), grant_id, rspcnt_of(other), exp, own_bit);
        end
        if (pressure) set_valid(other, 1'b1);
        set_taken(other, 1'b1);
        unstable = 0;
        for (int i = 0; i < hold; i++) begin
            tick();
            #1;
            if (rspv_of(owner) !== 1'b1 || rspd_of(owner) !== exp || m_a !== a || m_b !== b ||
                rspv_of(other) !== 1'b0)
                unstable++;
        end
        checks++;
        if (unstable != 0) begin
            failures++;
            $display("FAIL hold_req%0d: %0d unstable cycles out of %0d, required 0", owner, unstable, hold);
        end
        checks++;
        if (cnt_ready0 + cnt_ready1 != 1 || cnt_mia != 1 || cnt_mrt != 1) begin
            failures++;
            $display("FAIL pulses_req%0d: ready=%0d start=%0d result_taken=%0d, required 1 1 1",
                     owner, cnt_ready0 + cnt_ready1, cnt_mia, cnt_mrt);
        end
        set_taken(other, 1'b0);
        set_taken(owner, 1'b1);
        tick();
        set_taken(owner, 1'b0);
        #1;
        checks++;
        if (rspv_of(owner) !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL release_req%0d: rsp_valid=%b busy=%b, required 0 0", owner, rspv_of(owner), busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_req(0, 1'b1, 8'd3, 8'd4);
        set_req(1, 1'b1, 8'd5, 8'd6);
        tick();
        tick();
        #1;
        checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, m_input_available, m_result_taken, grant_id, busy} !== 8'h00) begin
            failures++;
            $display("FAIL reset_strobes: %b, required 00000000",
                     {req0_ready, req1_ready, rsp0_valid, rsp1_valid, m_input_available, m_result_taken, grant_id, busy});
        end
        checks++;
        if (m_a !== 8'd0 || m_b !== 8'd0 || rsp0_data !== 16'd0 || rsp1_data !== 16'd0) begin
            failures++;
            $display("FAIL reset_data: m_a=%0d m_b=%0d rsp0=%0d rsp1=%0d, required all 0", m_a, m_b, rsp0_data, rsp1_data);
        end
        set_valid(0, 1'b0);
        set_valid(1, 1'b0);
        reset = 1'b1;
        tick();
        #1;
        checks++;
        if (busy !== 1'b0 || m_a !== 8'd0 || rsp0_data !== 16'd0 || req0_ready !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle: busy=%b m_a=%0d rsp0=%0d ready0=%b, required 0 0 0 0",
                     busy, m_a, rsp0_data, req0_ready);
        end
    endtask

    task automatic test_single();
        mult_lat = 2;
        do_txn(0, 8'd6, 8'd7, 16'd42, 3, 1'b0);
    endtask

    task automatic test_simultaneous();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        mult_lat = 1;
        set_req(1, 1'b1, 8'd5, 8'd5);
        do_txn(0, 8'd3, 8'd4, 16'd12, 1, 1'b0);
        // Both contend again; requester 1 is now favoured.
        set_req(0, 1'b1, 8'd3, 8'd4);
        do_txn(1, 8'd5, 8'd5, 16'd25, 1, 1'b0);
        do_txn(0, 8'd3, 8'd4, 16'd12, 0, 1'b0);
    endtask

    task automatic test_zero_max();
        mult_lat = 0;
        do_txn(1, 8'd0, 8'd9, 16'd0, 1, 1'b0);
        do_txn(0, 8'd255, 8'd255, 16'd65025, 1, 1'b0);
    endtask

    task automatic test_slow_consumer();
        mult_lat = 3;
        set_req(0, 1'b0, 8'd2, 8'd3);
        do_txn(1, 8'd13, 8'd11, 16'd143, 20, 1'b1);
        do_txn(0, 8'd2, 8'd3, 16'd6, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        mult_lat = 10;
        set_req(1, 1'b1, 8'd9, 8'd8);
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_grant: ready1=%b, required 1", req1_ready);
        end
        tick();
        set_valid(1, 1'b0);
        tick();
        tick();
        #1;
        checks++;
        if (busy !== 1'b1 || grant_id !== 1'b1 || m_result_taken !== 1'b0) begin
            failures++;
            $display("FAIL midrst_wait: busy=%b grant=%b result_taken=%b, required 1 1 0", busy, grant_id, m_result_taken);
        end
        reset = 1'b0;
        set_valid(0, 1'b1);
        set_valid(1, 1'b1);
        #1;
        checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, m_input_available, m_result_taken, grant_id, busy} !== 8'h00 ||
            m_a !== 8'd0 || m_b !== 8'd0 || rsp0_data !== 16'd0 || rsp1_data !== 16'd0) begin
            failures++;
            $display("FAIL midrst_during: strobes=%b m_a=%0d m_b=%0d rsp0=%0d rsp1=%0d, required all 0",
                     {req0_ready, req1_ready, rsp0_valid, rsp1_valid, m_input_available, m_result_taken, grant_id, busy},
                     m_a, m_b, rsp0_data, rsp1_data);
        end
        tick();
        reset = 1'b1;
        set_valid(0, 1'b0);
        set_valid(1, 1'b0);
        #1;
        checks++;
        if (busy !== 1'b0 || grant_id !== 1'b0 || m_a !== 8'd0 || m_b !== 8'd0 ||
            rsp0_data !== 16'd0 || rsp1_data !== 16'd0 || rsp1_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_after: busy=%b grant=%b m_a=%0d m_b=%0d rsp0=%0d rsp1=%0d rsp1_valid=%b, required all 0",
                     busy, grant_id, m_a, m_b, rsp0_data, rsp1_data, rsp1_valid);
        end
        // Pointer was favouring requester 1 before reset; contention now goes to 0.
        set_req(1, 1'b1, 8'd7, 8'd9);
        do_txn(0, 8'd4, 8'd5, 16'd20, 0, 1'b0);
        do_txn(1, 8'd7, 8'd9, 16'd63, 2, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_zero_max();
        test_slow_consumer();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mult_arbiter
